// File: rtl/mbm_product_accumulator_if.sv
// rtl/mbm_product_accumulator_if.sv - product/result handshake bundle for the product accumulator
interface mbm_product_accumulator_if #(
    parameter int PROD_W = 129,
    parameter int ACC_W  = 136,
    parameter int CNT_W  = 8
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] product;
    logic              prod_last;
    logic              acc_clr;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  result;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;

    // master: the multiplier/consumer side; slave: the accumulator
    modport master (
        output prod_valid, product, prod_last, acc_clr, res_ready,
        input  prod_ready, res_valid, result, res_count, res_ovf
    );

    modport slave (
        input  prod_valid, product, prod_last, acc_clr, res_ready,
        output prod_ready, res_valid, result, res_count, res_ovf
    );
endinterface

// File: rtl/mbm_product_accumulator.sv
// rtl/mbm_product_accumulator.sv - burst accumulator for Booth multiplier products (MBM_ACC_SAT_EN selects saturation)
module mbm_product_accumulator #(
    parameter int PROD_W = 129,
    parameter int ACC_W  = 136,
    parameter int CNT_W  = 8
) (
    input logic                    clk,
    input logic                    rst,
    mbm_product_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        count;
    logic                    ovf;

    logic [ACC_W-1:0]        result_q;
    logic [CNT_W-1:0]        res_count_q;
    logic                    res_ovf_q;
    logic                    res_valid_q;

    logic                    beat;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] sum_raw;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt_base;
    logic [CNT_W-1:0]        cnt_next;
    logic                    ovf_base;
    logic                    ovf_add;

    // Ready depends on the state register alone so no input reaches it combinationally.
    assign bus.prod_ready = (state != HOLD);
    assign beat           = bus.prod_valid && (state != HOLD);

    assign prod_ext = ACC_W'($signed(bus.product));

    // A clear in the same cycle as a beat takes effect first, so the beat starts a new burst.
    assign acc_base = bus.acc_clr ? '0 : acc;
    assign cnt_base = bus.acc_clr ? '0 : count;
    assign ovf_base = bus.acc_clr ? 1'b0 : ovf;

    assign sum_raw  = acc_base + prod_ext;
    assign ovf_add  = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc_base[ACC_W-1]);
    assign cnt_next = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;

`ifdef MBM_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Overflow direction follows the operands' common sign.
    assign sum = ovf_add ? (acc_base[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
    assign sum = sum_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            result_q    <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        if (bus.prod_last) begin
                            result_q    <= sum;
                            res_count_q <= cnt_next;
                            res_ovf_q   <= ovf_base | ovf_add;
                            res_valid_q <= 1'b1;
                            acc         <= '0;
                            count       <= '0;
                            ovf         <= 1'b0;
                            state       <= HOLD;
                        end else begin
                            acc         <= sum;
                            count       <= cnt_next;
                            ovf         <= ovf_base | ovf_add;
                            state       <= ACCUM;
                        end
                    end else if (bus.acc_clr) begin
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.res_count = res_count_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_mbm_product_accumulator.sv
// tb/tb_mbm_product_accumulator.sv - scoreboard bench for the product accumulator
module tb_mbm_product_accumulator;

    localparam int PROD_W = 129;
    localparam int ACC_W  = 136;
    localparam int CNT_W  = 8;
    localparam int W2     = 129;

    typedef struct {
        logic [ACC_W-1:0] r;
        logic [CNT_W-1:0] c;
        logic             o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    exp_t q[$];

    logic signed [ACC_W-1:0] m_acc = '0;
    logic [CNT_W-1:0]        m_cnt = '0;
    logic                    m_ovf = 1'b0;

    mbm_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
    mbm_product_accumulator_if #(.PROD_W(W2), .ACC_W(W2), .CNT_W(CNT_W)) bus2 ();

    mbm_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mbm_product_accumulator #(.PROD_W(W2), .ACC_W(W2), .CNT_W(CNT_W)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    always #5 clk = ~clk;

    // Scoreboard: every result handshake is checked against the oldest expected burst.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_result got=%h required=none", bus.result);
            end else begin
                exp_t e;
                e = q.pop_front();
                tests_run++;
                if (bus.result !== e.r) begin
                    tests_failed++;
                    $display("FAIL sb_result got=%h required=%h", bus.result, e.r);
                end
                tests_run++;
                if (bus.res_count !== e.c) begin
                    tests_failed++;
                    $display("FAIL sb_count got=%0d required=%0d", bus.res_count, e.c);
                end
                tests_run++;
                if (bus.res_ovf !== e.o) begin
                    tests_failed++;
                    $display("FAIL sb_ovf got=%b required=%b", bus.res_ovf, e.o);
                end
            end
        end
    end

    task automatic model_clear();
        m_acc = '0;
        m_cnt = '0;
        m_ovf = 1'b0;
    endtask

    // Reference uses one extra bit of headroom to find the true sign of each sum.
    task automatic model_beat(input logic [PROD_W-1:0] v, input bit last, input bit clr);
        logic signed [ACC_W:0]   t;
        logic signed [ACC_W-1:0] ext;
        logic                    o;
        exp_t                    e;
        ext = ACC_W'($signed(v));
        if (clr) model_clear();
        t = (ACC_W+1)'(m_acc) + (ACC_W+1)'(ext);
        o = (t[ACC_W] != t[ACC_W-1]);
`ifdef MBM_ACC_SAT_EN
        if (o) m_acc = t[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else   m_acc = t[ACC_W-1:0];
`else
        m_acc = t[ACC_W-1:0];
`endif
        if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        m_ovf = m_ovf | o;
        if (last) begin
            e.r = m_acc;
            e.c = m_cnt;
            e.o = m_ovf;
            q.push_back(e);
            model_clear();
        end
    endtask

    task automatic send(input logic [PROD_W-1:0] v, input bit last, input bit clr, output int waits);
        waits = 0;
        bus.prod_valid = 1'b1;
        bus.product    = v;
        bus.prod_last  = last;
        bus.acc_clr    = clr;
        forever begin
            @(negedge clk);
            if (bus.prod_ready) break;
            waits++;
            if (waits > 50) begin
                tests_run++;
                tests_failed++;
                $display("FAIL send_timeout got=prod_ready_low required=prod_ready_high");
                break;
            end
        end
        if (waits <= 50) model_beat(v, last, clr);
        @(posedge clk);
        #1;
        bus.prod_valid = 1'b0;
        bus.prod_last  = 1'b0;
        bus.acc_clr    = 1'b0;
    endtask

    task automatic send_small(input longint signed x, input bit last, input bit clr);
        int w;
        send(PROD_W'(x), last, clr, w);
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 40) begin
            @(posedge clk);
            guard++;
        end
        tests_run++;
        if (q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain got=%0d pending required=0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (bus.res_valid !== 1'b0 || bus.result !== '0 || bus.res_count !== '0 ||
            bus.res_ovf !== 1'b0 || bus.prod_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state got=v%b r%h c%0d o%b rdy%b required=v0 r0 c0 o0 rdy1",
                     bus.res_valid, bus.result, bus.res_count, bus.res_ovf, bus.prod_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send_small(5, 0, 0);
        send_small(-3, 0, 0);
        send_small(10, 1, 0);
        tests_run++;
        if (bus.res_valid !== 1'b1 || bus.result !== ACC_W'(12) || bus.res_count !== CNT_W'(3)) begin
            tests_failed++;
            $display("FAIL basic_latency got=v%b r%0d c%0d required=v1 r12 c3",
                     bus.res_valid, bus.result, bus.res_count);
        end
        drain();
    endtask

    task automatic test_reset_mid_burst();
        send_small(100, 0, 0);
        send_small(200, 0, 0);
        send_small(300, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.res_valid !== 1'b0 || bus.result !== '0 || bus.res_count !== '0 ||
            bus.res_ovf !== 1'b0 || bus.prod_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset got=v%b r%h c%0d o%b rdy%b required=v0 r0 c0 o0 rdy1",
                     bus.res_valid, bus.result, bus.res_count, bus.res_ovf, bus.prod_ready);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_small(1, 0, 0);
        send_small(2, 1, 0);
        drain();
    endtask

    task automatic test_single_neg();
        logic [PROD_W-1:0] v;
        logic [ACC_W-1:0]  e;
        int                w;
        v = '0;
        v[PROD_W-1:127] = '1;
        e = '0;
        e[ACC_W-1:127] = '1;
        send(v, 1, 0, w);
        tests_run++;
        if (bus.result !== e || bus.res_count !== CNT_W'(1)) begin
            tests_failed++;
            $display("FAIL single_neg got=r%h c%0d required=r%h c1", bus.result, bus.res_count, e);
        end
        drain();
    endtask

    task automatic test_hold();
        int w;
        bus.res_ready = 1'b0;
        send_small(100, 1, 0);
        bus.prod_valid = 1'b1;
        bus.product    = PROD_W'(55);
        bus.prod_last  = 1'b0;
        bus.acc_clr    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.prod_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.result !== ACC_W'(100)) begin
                tests_failed++;
                $display("FAIL hold_stable got=rdy%b v%b r%0d required=rdy0 v1 r100",
                         bus.prod_ready, bus.res_valid, bus.result);
            end
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        send(PROD_W'(55), 0, 0, w);
        tests_run++;
        if (w !== 1) begin
            tests_failed++;
            $display("FAIL hold_release got=%0d wait_cycles required=1", w);
        end
        send_small(45, 1, 0);
        drain();
    endtask

    task automatic test_wrap();
        logic [W2-1:0] p;
        logic [W2-1:0] e;
        p = '0;
        p[127] = 1'b1;
`ifdef MBM_ACC_SAT_EN
        e = {1'b0, {(W2-1){1'b1}}};
`else
        e = '0;
        e[W2-1] = 1'b1;
`endif
        bus2.res_ready  = 1'b1;
        bus2.product    = p;
        bus2.prod_valid = 1'b1;
        bus2.prod_last  = 1'b0;
        @(posedge clk);
        #1;
        bus2.prod_last = 1'b1;
        @(posedge clk);
        #1;
        bus2.prod_valid = 1'b0;
        bus2.prod_last  = 1'b0;
        tests_run++;
        if (bus2.res_valid !== 1'b1 || bus2.result !== e || bus2.res_ovf !== 1'b1 ||
            bus2.res_count !== CNT_W'(2)) begin
            tests_failed++;
            $display("FAIL wrap got=v%b r%h o%b c%0d required=v1 r%h o1 c2",
                     bus2.res_valid, bus2.result, bus2.res_ovf, bus2.res_count, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clr_and_count();
        send_small(7, 0, 0);
        send_small(9, 0, 0);
        send_small(4, 1, 1);
        drain();
        for (int i = 0; i < 300; i++) send_small(1, (i == 299), 0);
        drain();
    endtask

    task automatic test_ovf_sticky();
        logic [PROD_W-1:0] mx;
        int                w;
        mx = {1'b0, {(PROD_W-1){1'b1}}};
        for (int i = 0; i < 130; i++) send(mx, 0, 0, w);
        send_small(-1, 1, 0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [PROD_W-1:0] v;
        int                len;
        int                w;
        for (int b = 0; b < 8; b++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                v = PROD_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
                if ($urandom_range(0, 1) == 0) v = PROD_W'($signed(v[40:0]));
                send(v, (i == len - 1), 0, w);
            end
        end
        drain();
    endtask

    initial begin
        bus.prod_valid  = 1'b0;
        bus.product     = '0;
        bus.prod_last   = 1'b0;
        bus.acc_clr     = 1'b0;
        bus.res_ready   = 1'b1;
        bus2.prod_valid = 1'b0;
        bus2.product    = '0;
        bus2.prod_last  = 1'b0;
        bus2.acc_clr    = 1'b0;
        bus2.res_ready  = 1'b1;

        test_reset();
        test_basic();
        test_reset_mid_burst();
        test_single_neg();
        test_hold();
        test_wrap();
        test_clr_and_count();
        test_ovf_sticky();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
